// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle instruction-phase FSM and datapath control for the MIPS-subset core
module mc_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [1:0] EOp,
  output logic [2:0] ALUOp,
  output logic       ALUSrcB,
  output logic [1:0] RegDst,
  output logic [1:0] WDSel,
  output logic [1:0] NPCOp,
  output logic       PCWr,
  output logic       IRWr,
  output logic       RFWr,
  output logic       MemWr,
  output logic       done,
  output logic [2:0] state
);
  localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXE = 3'd2, MEM = 3'd3, WB = 3'd4;
  logic [2:0] state_d;
  logic rtype, addu, subu, jr, ori, lw, sw, beq, lui, jal, nop;
  logic f, d, e, m, w;
  assign rtype = opcode == 6'b000000;
  assign addu  = rtype && funct == 6'b100001;
  assign subu  = rtype && funct == 6'b100011;
  assign jr    = rtype && funct == 6'b001000;
  assign ori   = opcode == 6'b001101;
  assign lw    = opcode == 6'b100011;
  assign sw    = opcode == 6'b101011;
  assign beq   = opcode == 6'b000100;
  assign lui   = opcode == 6'b001111;
  assign jal   = opcode == 6'b000011;
  assign nop   = !(addu | subu | jr | ori | lw | sw | beq | lui | jal);
  assign f = !reset && state == FETCH;
  assign d = !reset && state == DECODE;
  assign e = !reset && state == EXE;
  assign m = !reset && state == MEM;
  assign w = !reset && state == WB;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= FETCH;
    else state <= state_d;
  always_comb
    state_d = state == FETCH  ? DECODE :
              state == DECODE ? (nop ? FETCH : jal ? WB : EXE) :
              state == EXE    ? (lw | sw ? MEM : addu | subu | ori | lui ? WB : FETCH) :
              state == MEM    ? (lw ? WB : FETCH) : FETCH;
  always_comb begin
    EOp     = !(d | e | m | w) ? 2'b00 : ori ? 2'b01 : lui ? 2'b10 : beq ? 2'b11 : 2'b00;
    ALUOp   = !e ? 3'b000 : subu | beq ? 3'b001 : ori ? 3'b010 : lui ? 3'b011 : 3'b000;
    ALUSrcB = e & (ori | lui | lw | sw);
    RegDst  = !w ? 2'b00 : addu | subu ? 2'b01 : jal ? 2'b10 : 2'b00;
    WDSel   = !w ? 2'b00 : lw ? 2'b01 : jal ? 2'b10 : 2'b00;
    NPCOp   = e & beq ? 2'b01 : e & jr ? 2'b11 : w & jal ? 2'b10 : 2'b00;
    PCWr    = f | e & (beq & zero | jr) | w & jal;
    IRWr    = f;
    RFWr    = w;
    MemWr   = m & sw;
    done    = d & nop | e & (beq | jr) | m & sw | w;
  end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: self-checking bench for mc_ctrl against a per-class path model
module tb_mc_ctrl;
  typedef struct packed {
    logic [2:0] st;
    logic [1:0] eop;
    logic [2:0] aluop;
    logic       srcb;
    logic [1:0] regdst;
    logic [1:0] wdsel;
    logic [1:0] npc;
    logic       pcwr;
    logic       irwr;
    logic       rfwr;
    logic       memwr;
    logic       done;
  } exp_t;
  logic clk = 0, reset = 1, zero = 0;
  logic [5:0] opcode = 0, funct = 0;
  logic [1:0] EOp, RegDst, WDSel, NPCOp;
  logic [2:0] ALUOp, state;
  logic ALUSrcB, PCWr, IRWr, RFWr, MemWr, done;
  exp_t got;
  exp_t exp_q[$];
  int checks = 0, fails = 0;
  string cur = "init";
  mc_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .EOp(EOp), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .RegDst(RegDst), .WDSel(WDSel),
    .NPCOp(NPCOp), .PCWr(PCWr), .IRWr(IRWr), .RFWr(RFWr), .MemWr(MemWr),
    .done(done), .state(state)
  );
  always #5 clk = ~clk;
  assign got = {state, EOp, ALUOp, ALUSrcB, RegDst, WDSel, NPCOp, PCWr, IRWr, RFWr, MemWr, done};
  function automatic string cls(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'b000000) begin
      if (fn == 6'b100001) return "ADDU";
      if (fn == 6'b100011) return "SUBU";
      if (fn == 6'b001000) return "JR";
      return "NOP";
    end
    if (op == 6'b001101) return "ORI";
    if (op == 6'b100011) return "LW";
    if (op == 6'b101011) return "SW";
    if (op == 6'b000100) return "BEQ";
    if (op == 6'b001111) return "LUI";
    if (op == 6'b000011) return "JAL";
    return "NOP";
  endfunction
  function automatic void model(input logic [5:0] op, input logic [5:0] fn, input logic z, output exp_t q[$]);
    string c;
    int p[$];
    exp_t r;
    c = cls(op, fn);
    q = {};
    if (c == "ADDU" || c == "SUBU" || c == "ORI" || c == "LUI") p = '{0, 1, 2, 4};
    else if (c == "LW") p = '{0, 1, 2, 3, 4};
    else if (c == "SW") p = '{0, 1, 2, 3};
    else if (c == "BEQ" || c == "JR") p = '{0, 1, 2};
    else if (c == "JAL") p = '{0, 1, 4};
    else p = '{0, 1};
    foreach (p[i]) begin
      r = '0;
      r.st = 3'(p[i]);
      r.done = i == p.size() - 1;
      if (p[i] == 0) begin
        r.irwr = 1;
        r.pcwr = 1;
      end else r.eop = c == "ORI" ? 2'b01 : c == "LUI" ? 2'b10 : c == "BEQ" ? 2'b11 : 2'b00;
      if (p[i] == 2) begin
        if (c == "SUBU" || c == "BEQ") r.aluop = 3'b001;
        else if (c == "ORI") r.aluop = 3'b010;
        else if (c == "LUI") r.aluop = 3'b011;
        r.srcb = c == "ORI" || c == "LUI" || c == "LW" || c == "SW";
        if (c == "BEQ") begin
          r.npc = 2'b01;
          r.pcwr = z;
        end
        if (c == "JR") begin
          r.npc = 2'b11;
          r.pcwr = 1;
        end
      end
      if (p[i] == 3) r.memwr = c == "SW";
      if (p[i] == 4) begin
        r.rfwr = 1;
        r.regdst = (c == "ADDU" || c == "SUBU") ? 2'b01 : c == "JAL" ? 2'b10 : 2'b00;
        r.wdsel = c == "LW" ? 2'b01 : c == "JAL" ? 2'b10 : 2'b00;
        if (c == "JAL") begin
          r.npc = 2'b10;
          r.pcwr = 1;
        end
      end
      q.push_back(r);
    end
  endfunction
  task automatic chk(input string n, input int g, input int want);
    checks++;
    if (g != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", n, g, want);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input string n, input logic [5:0] op, input logic [5:0] fn, input logic z, input bit glitch);
    exp_t q[$];
    model(op, fn, z, q);
    cur = n;
    foreach (q[i]) exp_q.push_back(q[i]);
    opcode = glitch ? ~op : op;
    funct = glitch ? ~fn : fn;
    zero = z;
    if (glitch) begin
      @(negedge clk);
      #1;
      opcode = op;
      funct = fn;
    end
    repeat (q.size()) step();
  endtask
  always @(negedge clk)
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        fails++;
        $display("FAIL %s cycle: got state=%0d outs=%h, want state=%0d outs=%h", cur, got.st, got, e.st, e);
      end
    end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    exp_t q[$];
    model(6'b100011, 6'b000000, 1'b0, q);
    chk("model_lw_len", q.size(), 5);
    chk("model_lw_wdsel", int'(q[4].wdsel), 1);
    model(6'b111111, 6'b000000, 1'b0, q);
    chk("model_nop_len", q.size(), 2);
    chk("model_nop_done", int'(q[1].done), 1);
    model(6'b000011, 6'b000000, 1'b0, q);
    chk("model_jal_wb", int'(q[2].st), 4);
    chk("model_jal_npc", int'(q[2].npc), 2);
    model(6'b000100, 6'b000000, 1'b0, q);
    chk("model_beq_pcwr", int'(q[2].pcwr), 0);
    chk("model_beq_eop", int'(q[2].eop), 3);
    model(6'b001101, 6'b000000, 1'b0, q);
    chk("model_ori_aluop", int'(q[2].aluop), 2);
    step();
    cur = "reset";
    exp_q.push_back('0);
    exp_q.push_back('0);
    repeat (2) step();
    reset = 0;
    run("ORI", 6'b001101, 6'b000000, 1'b0, 1'b0);
    run("LUI", 6'b001111, 6'b101010, 1'b0, 1'b1);
    run("LW", 6'b100011, 6'b000000, 1'b0, 1'b0);
    run("SW", 6'b101011, 6'b000000, 1'b0, 1'b1);
    run("BEQ_z1", 6'b000100, 6'b000000, 1'b1, 1'b0);
    run("BEQ_z0", 6'b000100, 6'b000000, 1'b0, 1'b0);
    run("JAL", 6'b000011, 6'b000000, 1'b0, 1'b0);
    run("JR", 6'b000000, 6'b001000, 1'b0, 1'b0);
    run("NOP_ff", 6'b111111, 6'b111111, 1'b0, 1'b0);
    run("NOP_zero", 6'b000000, 6'b000000, 1'b0, 1'b0);
    run("ADDU", 6'b000000, 6'b100001, 1'b0, 1'b0);
    run("SUBU", 6'b000000, 6'b100011, 1'b1, 1'b0);
    model(6'b100011, 6'b000000, 1'b0, q);
    cur = "LW_rst";
    for (int i = 0; i < 4; i++) exp_q.push_back(q[i]);
    opcode = 6'b100011;
    funct = 6'b000000;
    repeat (4) step();
    reset = 1;
    exp_q.push_back('0);
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_rfwr", int'(RFWr), 0);
    step();
    reset = 0;
    #1;
    chk("post_rst_irwr", int'(IRWr), 1);
    chk("post_rst_pcwr", int'(PCWr), 1);
    run("ADDU_after_rst", 6'b000000, 6'b100001, 1'b0, 1'b0);
    run("JR_end", 6'b000000, 6'b001000, 1'b0, 1'b0);
    step();
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit for the single-issue MIPS-subset core. It holds the instruction-phase state machine and, each cycle, drives the write enables and datapath selects, including `EOp` for the immediate extender, the ALU operation, the next-PC source and the register-file write path. It sits between the instruction register (opcode/funct) and the datapath. It owns no data storage beyond its state register.

## Interface
- No parameters.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; forces state to FETCH.
- `opcode`  in  6  IR[31:26]; stable from the cycle after FETCH.
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU equality flag, valid in EXE.
- `EOp`  out  2  extender mode: 00 sign, 01 zero, 10 upper (lui), 11 sign<<2 (branch).
- `ALUOp`  out  3  000 add, 001 sub, 010 or, 011 pass B.
- `ALUSrcB`  out  1  0 rt data, 1 extender output.
- `RegDst`  out  2  00 rt, 01 rd, 10 $31.
- `WDSel`  out  2  00 ALU result, 01 memory data, 10 PC (already PC+4).
- `NPCOp`  out  2  00 PC+4, 01 branch, 10 jump (jal), 11 register (jr).
- `PCWr`, `IRWr`, `RFWr`, `MemWr`  out  1 each  write enables.
- `done`  out  1  high in the final cycle of every instruction.
- `state`  out  3  current state, for debug.

## Operation
- States: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4. Values 5–7 are illegal and return to FETCH on the next edge.
- Decoded classes: ADDU (op 000000, funct 100001), SUBU (000000/100011), JR (000000/001000), ORI 001101, LW 100011, SW 101011, BEQ 000100, LUI 001111, JAL 000011. Every other encoding, including sll-nop, is NOP.
- Paths:
  - ADDU/SUBU/ORI/LUI: F→D→E→W.
  - LW: F→D→E→M→W.
  - SW: F→D→E→M.
  - BEQ: F→D→E.
  - JR: F→D→E.
  - JAL: F→D→W.
  - NOP: F→D. After its final state each path returns to F.
- FETCH: IRWr=1, PCWr=1, NPCOp=00.
- DECODE: no enables. `done`=1 only for NOP.
- EXE:
  - ADDU: ALUOp add, ALUSrcB 0.
  - SUBU: ALUOp sub, ALUSrcB 0.
  - ORI: ALUOp or, ALUSrcB 1.
  - LUI: ALUOp pass B, ALUSrcB 1.
  - LW/SW: ALUOp add, ALUSrcB 1.
  - BEQ: ALUOp sub, ALUSrcB 0, NPCOp 01, PCWr=zero, done=1.
  - JR: NPCOp 11, PCWr=1, done=1.
- MEM: MemWr=1 for SW (done=1). LW reads only.
- WB: RFWr=1, done=1.
  - ADDU/SUBU: RegDst 01, WDSel 00.
  - ORI/LUI: RegDst 00, WDSel 00.
  - LW: RegDst 00, WDSel 01.
  - JAL: RegDst 10, WDSel 10, NPCOp 10, PCWr=1. The RF write uses the pre-update PC.
- EOp is a function of opcode only, constant in every state after FETCH:
  - ORI → 01.
  - LUI → 10.
  - BEQ → 11.
  - All else → 00.
  - In FETCH, EOp=00.
- Every output not listed for a state is 0.

## Timing
- State register updates on the rising `clk` edge. All outputs are combinational from state, opcode, funct and zero (Moore per class).
- Reset asynchronous: state=FETCH immediately. While `reset`=1, PCWr/IRWr/RFWr/MemWr/done are forced to 0 and all selects are 0. The first FETCH with enables active is the first cycle after reset deasserts.
- Reset mid-instruction (any state) aborts the instruction. No write enable is asserted in the reset cycle.
- Latency in cycles:
  - NOP: 2.
  - BEQ, JR, JAL: 3.
  - ADDU, SUBU, ORI, LUI, SW: 4.
  - LW: 5.
- `done` lasts exactly one cycle per instruction. FETCH always follows.
- BEQ with zero=0: PCWr=0 and done=1; the PC keeps its PC+4 value.
- `opcode`/`funct` changing during FETCH (IR load) does not affect the FETCH outputs.

## Test plan
- Reset: assert reset in WB of an LW → state=0 within the same cycle, RFWr=0. Release reset → next cycle IRWr=PCWr=1.
- ORI then LUI: in EXE, EOp=01, ALUSrcB=1, ALUOp=010. Then EOp=10, ALUOp=011. WB has RFWr=1, RegDst=00. 4 cycles each, with done on the 4th.
- LW then SW: LW state sequence 0,1,2,3,4 with WDSel=01 in WB. SW sequence 0,1,2,3 with MemWr=1 only in state 3.
- BEQ: with zero=1 in EXE → PCWr=1, NPCOp=01, EOp=11. Repeat with zero=0 → PCWr=0. Both take 3 cycles.
- JAL and JR: JAL state sequence 0,1,4 with RegDst=10, WDSel=10, NPCOp=10, PCWr=RFWr=1. JR state sequence 0,1,2 with NPCOp=11, RFWr=0.
- Unknown opcode 111111 and the all-zero word: 2 cycles, done in DECODE, no write enable after FETCH.
